display_scan_ctrl: RTL and testbench
====================================

DISPLAY_SCAN_CTRL -- requirements
Module: display_scan_ctrl

Interface
REQ-001: Parameter NUM_DIGITS, default 4, SHALL set the number of multiplexed 7-segment digits (range 2..8).
REQ-002: Parameter SCAN_DIV, default 50000, SHALL set the clk cycles per digit slot (minimum 4).
REQ-003: Parameter GUARD, default 2, SHALL set the anode-off cycles at the start of each slot (0..SCAN_DIV-1).
REQ-004: clk  in  1  the single clock; all logic SHALL be on its rising edge.
REQ-005: rst  in  1  reset, synchronous, active-high.
REQ-006: enable  in  1  scan enable; low freezes the scan and blanks the display.
REQ-007: upd_valid  in  1  new digit set offered.
REQ-008: upd_digits  in  4*NUM_DIGITS  BCD digits; nibble 0 is the least significant (rightmost) digit.
REQ-009: upd_dp  in  NUM_DIGITS  decimal-point mask; bit i lights the DP of digit i.
REQ-010: upd_ready  out  1  block can accept an update.
REQ-011: seg_code  out  8  active-low segments {dp,g,f,e,d,c,b,a}; 8'hFF is blank.
REQ-012: digit_an  out  NUM_DIGITS  active-low anode selects; at most one bit low at any time.
REQ-013: frame_done  out  1  one-cycle pulse when the scan wraps from digit NUM_DIGITS-1 to digit 0.

Function
REQ-014: The prescaler SHALL count 0..SCAN_DIV-1 and wrap; tick SHALL be asserted when count==SCAN_DIV-1 and enable==1.
REQ-015: On tick the digit index SHALL advance by one and wrap NUM_DIGITS-1 -> 0; frame_done SHALL pulse in the cycle after the wrapping tick.
REQ-016: seg_code and digit_an SHALL be registered, reflecting the index/count values of the previous cycle (1-cycle latency).
REQ-017: While count < GUARD, digit_an SHALL be all ones (anti-ghosting); otherwise bit idx SHALL be 0 and all other bits 1.
REQ-018: Decode: nibble 0..9 SHALL map to the standard active-low code (e.g. 0 -> 8'hC0, 8 -> 8'h80); nibble 10..15 SHALL display blank 8'hFF.
REQ-019: When the display DP bit for the current digit is set, seg_code[7] SHALL be 0 regardless of the nibble value, including blanked nibbles.
REQ-020: Handshake: an update SHALL be accepted when upd_valid && upd_ready; accepted data SHALL go to a pending register, and upd_ready SHALL drop in the next cycle.
REQ-021: Pending data SHALL be committed to the display register on the wrapping tick only; upd_ready SHALL rise in the cycle after the commit (no tearing within a frame).
REQ-022: An update accepted in the same cycle as the wrapping tick SHALL NOT be committed by that tick; it SHALL commit at the following wrap.
REQ-023: With enable=0: the count and index SHALL hold, seg_code=8'hFF, digit_an all ones, and no commit SHALL occur; handshake acceptance SHALL still operate.
REQ-024: With enable=0, frame_done SHALL stay 0.

Reset
REQ-025: On rst: count=0, index=0, display and pending digits=0, DP mask=0, and pending flag cleared.
REQ-026: Outputs after rst: seg_code=8'hFF, digit_an all ones, frame_done=0, upd_ready=1.
REQ-027: Reset mid-frame or mid-handshake SHALL discard pending data, and the first slot after reset SHALL be digit 0.

Configuration
REQ-028: Macro DISPLAY_LZ_BLANK_EN defined: a zero digit SHALL display blank (DP still honoured) when it and every more significant digit are zero; digit 0 SHALL always be displayed.
REQ-029: DISPLAY_LZ_BLANK_EN undefined: all digits SHALL be displayed per REQ-018, with no leading-zero logic synthesized.

Structure
REQ-030: Shared package timer_pkg SHALL hold SEG_BLANK (8'hFF), the 10-entry BCD segment-code table, and the default SCAN_DIV/GUARD constants.
REQ-031: The prescaler and tick generation SHALL be a sub-module scan_tick_gen (outputs count and tick); all other logic SHALL stay in display_scan_ctrl.

Verification (NUM_DIGITS=4, SCAN_DIV=8, GUARD=2)
REQ-032: Reset, then enable=1 -> digit_an sequence 1111,1111,1110 x6,1111,1111,1101 x6,..., and frame_done pulses every 32 cycles.
REQ-033: Update 16'h1234 with dp=4'b0100 -> after the next frame_done, digit 2 slot shows seg_code=8'h24 (2 with DP lit), and upd_ready returns to 1.
REQ-034: upd_valid asserted in the wrapping-tick cycle -> old digits remain for a full frame and the new digits appear from the next frame.
REQ-035: Nibble 4'hC on digit 1 -> seg_code=8'hFF in the digit 1 slot; with DISPLAY_LZ_BLANK_EN and 16'h0050, digits 3 and 2 are blank and digit 0 shows 8'hC0.
REQ-036: enable=0 mid-slot for 20 cycles -> outputs blank and the index is frozen; on enable=1 the scan resumes at the same count; rst asserted mid-frame -> REQ-026 values appear on the next cycle.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared constants for the multiplexed 7-segment display scanner:
// the blank code, the BCD segment table and the default timing values.
package timer_pkg;

  localparam logic [7:0] SEG_BLANK        = 8'hFF;
  localparam int         DEFAULT_SCAN_DIV = 50000;
  localparam int         DEFAULT_GUARD    = 2;

  typedef logic [3:0] bcd_t;

  // Active-low {dp,g,f,e,d,c,b,a} codes, entry n is the glyph for digit n.
  localparam logic [9:0][7:0] SEG_TABLE = {
    8'h90, 8'h80, 8'hF8, 8'h82, 8'h92,
    8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

  // Nibbles 10..15 have no glyph and show blank.
  function automatic logic [7:0] seg_decode(input bcd_t nib);
    logic [7:0] code;
    code = SEG_BLANK;
    if (nib <= 4'd9) code = SEG_TABLE[nib];
    return code;
  endfunction

endpackage

// File: rtl/display_scan_ctrl_if.sv
// Update handshake between a digit producer (master) and the scanner (slave).
interface display_scan_ctrl_if #(
  parameter int NUM_DIGITS = 4
);
  logic                    upd_valid;
  logic [4*NUM_DIGITS-1:0] upd_digits;
  logic [NUM_DIGITS-1:0]   upd_dp;
  logic                    upd_ready;

  modport master (output upd_valid, output upd_digits, output upd_dp, input upd_ready);
  modport slave  (input upd_valid, input upd_digits, input upd_dp, output upd_ready);
endinterface

// File: rtl/display_scan_ctrl_scan_tick_gen.sv
// Slot prescaler: counts 0..SCAN_DIV-1 while enabled and flags the last
// cycle of each digit slot.
module scan_tick_gen #(
  parameter int SCAN_DIV = 8,
  parameter int CW       = $clog2(SCAN_DIV)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enable_i,
  output logic [CW-1:0] count_o,
  output logic          tick_o
);
  logic [CW-1:0] count_q;
  logic          last_slot_cycle;

  assign last_slot_cycle = (count_q == CW'(SCAN_DIV - 1));

  // Prescaler: advance while enabled, wrap at the end of the slot, hold otherwise.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking '<=' so every flop samples pre-edge values.
    if (rst)           count_q <= '0;
    else if (enable_i) count_q <= last_slot_cycle ? '0 : count_q + 1'b1;
  end

  assign count_o = count_q;
  assign tick_o  = enable_i && last_slot_cycle;
endmodule

// File: rtl/display_scan_ctrl.sv
// Multiplexed 7-segment scan controller with a tear-free update handshake.
// New digits are parked in a pending register and only committed on the
// frame wrap. Optional leading-zero blanking: define DISPLAY_LZ_BLANK_EN.
module display_scan_ctrl
  import timer_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = DEFAULT_SCAN_DIV,
  parameter int GUARD      = DEFAULT_GUARD
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  display_scan_ctrl_if.slave    upd,
  output logic [7:0]            seg_code,
  output logic [NUM_DIGITS-1:0] digit_an,
  output logic                  frame_done
);
  localparam int CW = $clog2(SCAN_DIV);
  localparam int IW = $clog2(NUM_DIGITS);

  logic [CW-1:0] count;
  logic          tick;

  scan_tick_gen #(.SCAN_DIV(SCAN_DIV), .CW(CW)) u_tick (
    .clk      (clk),
    .rst      (rst),
    .enable_i (enable),
    .count_o  (count),
    .tick_o   (tick)
  );

  logic [IW-1:0]                 idx_q, idx_d;
  logic                          wrap_tick;
  logic [NUM_DIGITS-1:0][3:0]    disp_q, pend_q;
  logic [NUM_DIGITS-1:0]         disp_dp_q, pend_dp_q;
  logic                          pending_q;
  logic                          accept;
  logic [NUM_DIGITS-1:0]         blank_lz;
  logic [7:0]                    seg_d, seg_q;
  logic [NUM_DIGITS-1:0]         an_d, an_q;
  logic                          frame_done_q;

  // Digit index next state: step on every slot tick, wrap after the last digit.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    idx_d     = idx_q;
    wrap_tick = tick && (idx_q == IW'(NUM_DIGITS - 1));
    if (tick) idx_d = wrap_tick ? '0 : idx_q + 1'b1;
  end

  // Only one update may be parked at a time; a full pending slot back-pressures.
  assign upd.upd_ready = !pending_q;
  assign accept        = upd.upd_valid && !pending_q;

  // Handshake and commit: park accepted data, move it to the display on wrap only.
  always_ff @(posedge clk) begin
    // NOTE: these are plain registers that drive visible output, so they are reset
    // (unlike a RAM array, which would be left unreset).
    if (rst) begin
      pending_q <= 1'b0;
      pend_q    <= '0;
      pend_dp_q <= '0;
      disp_q    <= '0;
      disp_dp_q <= '0;
    end else if (accept) begin
      pending_q <= 1'b1;
      pend_q    <= upd.upd_digits;
      pend_dp_q <= upd.upd_dp;
    end else if (wrap_tick && pending_q) begin
      pending_q <= 1'b0;
      disp_q    <= pend_q;
      disp_dp_q <= pend_dp_q;
    end
  end

`ifdef DISPLAY_LZ_BLANK_EN
  // Leading-zero scan from the most significant digit down; digit 0 never blanks.
  always_comb begin : lz_scan
    logic zeros_above;
    zeros_above = 1'b1;
    blank_lz    = '0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      blank_lz[i] = zeros_above && (disp_q[i] == 4'd0);
      zeros_above = blank_lz[i];
    end
  end
`else
  assign blank_lz = '0;
`endif

  // Output next state: decode current digit, DP overrides blanking, anode off in guard.
  always_comb begin
    seg_d = SEG_BLANK;
    an_d  = '1;
    if (enable) begin
      if (!blank_lz[idx_q]) seg_d = seg_decode(disp_q[idx_q]);
      if (disp_dp_q[idx_q]) seg_d[7] = 1'b0;
      if (count >= CW'(GUARD)) an_d[idx_q] = 1'b0;
    end
  end

  // Scan index and registered display outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q        <= '0;
      seg_q        <= SEG_BLANK;
      an_q         <= '1;
      frame_done_q <= 1'b0;
    end else begin
      idx_q        <= idx_d;
      seg_q        <= seg_d;
      an_q         <= an_d;
      frame_done_q <= wrap_tick;
    end
  end

  assign seg_code   = seg_q;
  assign digit_an   = an_q;
  assign frame_done = frame_done_q;
endmodule

// File: tb/tb_display_scan_ctrl.sv
// Self-checking bench for display_scan_ctrl (4 digits, 8-cycle slots, 2-cycle guard).
// A frame-arithmetic model predicts every output each cycle; literal checks pin it.
module tb_display_scan_ctrl;
  localparam int ND = 4;
  localparam int SD = 8;
  localparam int GD = 2;

  logic clk = 1'b0;
  logic rst;
  logic enable;
  logic [7:0]    seg_code;
  logic [ND-1:0] digit_an;
  logic          frame_done;

  always #5 clk = ~clk;

  display_scan_ctrl_if #(.NUM_DIGITS(ND)) upd_if ();

  display_scan_ctrl #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .GUARD(GD)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .upd        (upd_if),
    .seg_code   (seg_code),
    .digit_an   (digit_an),
    .frame_done (frame_done)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0] seg_tab [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                               8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
  int            e_cnt;          // enabled cycles since reset
  int            m_disp [ND];
  int            m_pend [ND];
  logic [ND-1:0] m_dp, m_pend_dp;
  bit            m_pend_v;
  bit            m_live = 0;
  logic [7:0]    exp_seg;
  logic [ND-1:0] exp_an;
  logic          exp_fd;
  logic          exp_ready;

  function automatic logic [7:0] model_seg(input int dig);
    logic [7:0] s;
`ifdef DISPLAY_LZ_BLANK_EN
    bit lz;
`endif
    s = (m_disp[dig] <= 9) ? seg_tab[m_disp[dig]] : 8'hFF;
`ifdef DISPLAY_LZ_BLANK_EN
    lz = (dig != 0);
    for (int j = dig; j < ND; j++) if (m_disp[j] != 0) lz = 0;
    if (lz) s = 8'hFF;
`endif
    if (m_dp[dig]) s[7] = 1'b0;
    return s;
  endfunction

  always @(posedge clk) begin : model
    int  pos, dig;
    bit  wrap;
    if (rst) begin
      e_cnt = 0; m_dp = '0; m_pend_dp = '0; m_pend_v = 0;
      for (int i = 0; i < ND; i++) begin m_disp[i] = 0; m_pend[i] = 0; end
      exp_seg = 8'hFF; exp_an = '1; exp_fd = 0;
      m_live = 1;
    end else begin
      pos  = e_cnt % SD;
      dig  = (e_cnt / SD) % ND;
      wrap = enable && (pos == SD - 1) && (dig == ND - 1);
      exp_seg = 8'hFF;
      exp_an  = '1;
      if (enable) begin
        exp_seg = model_seg(dig);
        if (pos >= GD) exp_an[dig] = 1'b0;
      end
      exp_fd = wrap;
      if (wrap && m_pend_v) begin
        m_disp = m_pend; m_dp = m_pend_dp; m_pend_v = 0;
      end else if (upd_if.upd_valid && !m_pend_v) begin
        for (int i = 0; i < ND; i++) m_pend[i] = int'(upd_if.upd_digits[4*i +: 4]);
        m_pend_dp = upd_if.upd_dp; m_pend_v = 1;
      end
      if (enable) e_cnt++;
    end
    exp_ready = !m_pend_v;
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (m_live) begin
      check("seg_code", seg_code, exp_seg);
      check("digit_an", digit_an, exp_an);
      check("frame_done", frame_done, exp_fd);
      check("upd_ready", upd_if.upd_ready, exp_ready);
      check("an_onehot", ($countones(~digit_an) <= 1), 1);
    end
  end

  // ---------------- helpers ----------------
  task automatic wait_fd(input string name);
    int n = 0;
    @(negedge clk);
    while (frame_done !== 1'b1 && n < 80) begin @(negedge clk); n++; end
    check({name, "_fd_seen"}, frame_done, 1'b1);
  endtask

  task automatic wait_an(input logic [ND-1:0] target, input string name);
    int n = 0;
    @(negedge clk);
    while (digit_an !== target && n < 64) begin @(negedge clk); n++; end
    check({name, "_an_seen"}, digit_an, target);
  endtask

  task automatic offer(input logic [15:0] digits, input logic [3:0] dp);
    upd_if.upd_valid  = 1'b1;
    upd_if.upd_digits = digits;
    upd_if.upd_dp     = dp;
    @(negedge clk);
    check("offer_ready_drop", upd_if.upd_ready, 1'b0);
    upd_if.upd_valid  = 1'b0;
  endtask

  logic [ND-1:0] an_seq [16] = '{4'hF, 4'hF, 4'hE, 4'hE, 4'hE, 4'hE, 4'hE, 4'hE,
                                 4'hF, 4'hF, 4'hD, 4'hD, 4'hD, 4'hD, 4'hD, 4'hD};

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1; enable = 1'b0;
    upd_if.upd_valid = 1'b0; upd_if.upd_digits = '0; upd_if.upd_dp = '0;
    repeat (3) @(negedge clk);
    check("rst_seg", seg_code, 8'hFF);
    check("rst_an", digit_an, 4'hF);
    check("rst_fd", frame_done, 1'b0);
    check("rst_ready", upd_if.upd_ready, 1'b1);

    // Scan order with guard band, zeros on display after reset.
    rst = 1'b0; enable = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      check("scan_an_seq", digit_an, an_seq[i]);
      if (i < 8) check("scan_seg_zero", seg_code, 8'hC0);
    end

    wait_fd("first");
    n = 0;
    do begin @(negedge clk); n++; end while (frame_done !== 1'b1 && n < 80);
    check("frame_period", n, 32);

    // Update with DP on digit 2, committed at the next wrap.
    offer(16'h1234, 4'b0100);
    wait_fd("commit1");
    check("ready_back", upd_if.upd_ready, 1'b1);
    wait_an(4'b1011, "d2");
    check("d2_dp_seg", seg_code, 8'h24);

    // Update offered exactly in the wrapping-tick cycle waits one full frame.
    wait_fd("pre_wrap");
    repeat (31) @(negedge clk);
    upd_if.upd_valid = 1'b1; upd_if.upd_digits = 16'h5678; upd_if.upd_dp = 4'b0000;
    @(negedge clk);
    check("wrap_accept_fd", frame_done, 1'b1);
    check("wrap_accept_ready", upd_if.upd_ready, 1'b0);
    upd_if.upd_valid = 1'b0;
    wait_an(4'hE, "old_d0");
    check("old_frame_d0", seg_code, 8'h99);
    wait_fd("new_frame");
    wait_an(4'hE, "new_d0");
    check("new_frame_d0", seg_code, 8'h80);

    // Non-BCD nibble blanks its digit.
    offer(16'h12C4, 4'b0000);
    wait_fd("nib_c");
    wait_an(4'hD, "d1");
    check("nib_c_blank", seg_code, 8'hFF);

    // Leading zeros, with a DP on a leading-zero digit.
    offer(16'h0050, 4'b1000);
    wait_fd("lz");
    wait_an(4'hE, "lz_d0");
    check("lz_d0", seg_code, 8'hC0);
    wait_an(4'hB, "lz_d2");
`ifdef DISPLAY_LZ_BLANK_EN
    check("lz_d2", seg_code, 8'hFF);
`else
    check("lz_d2", seg_code, 8'hC0);
`endif
    wait_an(4'h7, "lz_d3");
`ifdef DISPLAY_LZ_BLANK_EN
    check("lz_d3_dp", seg_code, 8'h7F);
`else
    check("lz_d3_dp", seg_code, 8'h40);
`endif

    // Freeze mid-slot; handshake still accepts while frozen.
    wait_fd("pre_freeze");
    wait_an(4'hD, "freeze_d1");
    enable = 1'b0;
    offer(16'h4321, 4'b0000);
    check("off_seg", seg_code, 8'hFF);
    check("off_an", digit_an, 4'hF);
    repeat (19) @(negedge clk);
    enable = 1'b1;
    @(negedge clk);
    check("resume_an", digit_an, 4'hD);
    check("resume_seg", seg_code, 8'h92);

    // Reset mid-frame with an update still pending.
    rst = 1'b1;
    @(negedge clk);
    check("midrst_seg", seg_code, 8'hFF);
    check("midrst_an", digit_an, 4'hF);
    check("midrst_fd", frame_done, 1'b0);
    check("midrst_ready", upd_if.upd_ready, 1'b1);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post_rst_an", digit_an, an_seq[i]);
    end
    check("post_rst_seg", seg_code, 8'hC0);
    wait_fd("discard");
    wait_an(4'hE, "discard_d0");
    check("pending_discarded", seg_code, 8'hC0);

    // Randomized traffic against the model.
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      enable = ($urandom_range(0, 19) != 0);
      rst    = ($urandom_range(0, 499) == 0);
      upd_if.upd_valid  = ($urandom_range(0, 7) == 0);
      upd_if.upd_digits = 16'($urandom);
      if ($urandom_range(0, 2) == 0) upd_if.upd_digits = upd_if.upd_digits & 16'h00FF;
      upd_if.upd_dp     = 4'($urandom);
    end
    rst = 1'b0; upd_if.upd_valid = 1'b0;
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
